pll_rst_seq: RTL and testbench

Reset sequencer that sits directly downstream of the PLL clock IP inside `top`. It consumes the PLL `locked` flag, which is asynchronous to `sys_clk`, and filters it for stability. After a hold-off it releases a set of active-low domain resets in staggered order. It re-asserts them on any lock loss and counts lock-loss events for debug.

---
 rtl/pll_rst_pkg.sv | 7 +
 rtl/sync_ff.sv | 15 +
 rtl/pll_rst_seq.sv | 102 ++++++++++
 tb/tb_pll_rst_seq.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: state encoding and counter width helper for the PLL reset sequencer
package pll_rst_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, FILTER, HOLD, RELEASE, RUN} state_t;
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val) + 1;
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop single-bit synchronizer with async active-low reset
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: filters PLL lock, then releases staggered domain resets and counts lock losses
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int NUM_DOMAINS = 3,
  parameter int STAGE_GAP   = 8,
  parameter int CNT_W       = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   pll_locked,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   ready,
  output logic [CNT_W-1:0]       lock_loss_cnt
);
  localparam int REL_MAX  = (NUM_DOMAINS - 1) * STAGE_GAP;
  localparam int STEP_MAX = LOCK_FILTER > HOLD_CYCLES ? (LOCK_FILTER > REL_MAX ? LOCK_FILTER : REL_MAX)
                                                      : (HOLD_CYCLES > REL_MAX ? HOLD_CYCLES : REL_MAX);
  localparam int STEP_W   = cnt_w(STEP_MAX);
  localparam logic [STEP_W-1:0] LF_C = STEP_W'(LOCK_FILTER);
  localparam logic [STEP_W-1:0] HC_C = STEP_W'(HOLD_CYCLES);
  state_t                   state, state_nx;
  logic [STEP_W-1:0]        step, step_nx, step_inc;
  logic [NUM_DOMAINS-1:0]   rst_nx, rel;
  logic                     ready_nx, locked_s;
  logic [CNT_W-1:0]         loss_nx;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (sys_clk),
    .rst_n(sys_rst),
    .d    (pll_locked),
    .q    (locked_s)
  );
  always_comb begin
    state_nx = state;
    step_nx  = step;
    rst_nx   = rst_n_out;
    ready_nx = ready;
    loss_nx  = lock_loss_cnt;
    step_inc = step + STEP_W'(1);
    rel      = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) rel[i] = step_inc >= STEP_W'(i * STAGE_GAP);
    case (state)
      WAIT_LOCK: begin
        step_nx  = '0;
        rst_nx   = '0;
        ready_nx = 1'b0;
        // the cycle that first sees lock counts as the first filter cycle
        if (locked_s) begin
          state_nx = LOCK_FILTER == 1 ? HOLD : FILTER;
          step_nx  = LOCK_FILTER == 1 ? '0 : STEP_W'(1);
        end
      end
      FILTER: begin
        state_nx = !locked_s ? WAIT_LOCK : step_inc == LF_C ? HOLD : FILTER;
        step_nx  = !locked_s || step_inc == LF_C ? '0 : step_inc;
      end
      HOLD: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          step_nx  = '0;
        end else if (step_inc == HC_C) begin
          state_nx = NUM_DOMAINS == 1 ? RUN : RELEASE;
          step_nx  = '0;
          rst_nx   = NUM_DOMAINS'(1);
          ready_nx = NUM_DOMAINS == 1;
        end else step_nx = step_inc;
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_nx = WAIT_LOCK;
          step_nx  = '0;
          rst_nx   = '0;
          ready_nx = 1'b0;
          loss_nx  = &lock_loss_cnt ? lock_loss_cnt : lock_loss_cnt + CNT_W'(1);
        end else if (state == RELEASE) begin
          step_nx  = step_inc;
          rst_nx   = rel;
          state_nx = rel[NUM_DOMAINS-1] ? RUN : RELEASE;
          ready_nx = rel[NUM_DOMAINS-1];
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end
  always_ff @(posedge sys_clk or negedge sys_rst)
    if (!sys_rst) begin
      state         <= WAIT_LOCK;
      step          <= '0;
      rst_n_out     <= '0;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_nx;
      step          <= step_nx;
      rst_n_out     <= rst_nx;
      ready         <= ready_nx;
      lock_loss_cnt <= loss_nx;
    end
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: scoreboard bench; expected output changes are queued with their cycle and checked by a monitor
module tb_pll_rst_seq;
  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       rdy;
    logic [3:0] cnt;
  } exp_t;
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       pll_locked;
  logic [2:0] rst_n_out;
  logic       ready;
  logic [3:0] lock_loss_cnt;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         s = 0;
  logic [3:0] cnt_m = 4'd0;
  logic [7:0] prev = 8'h00;
  exp_t       q[$];
  exp_t       em;

  pll_rst_seq #(
    .SYNC_STAGES(2), .LOCK_FILTER(4), .HOLD_CYCLES(8),
    .NUM_DOMAINS(3), .STAGE_GAP(2), .CNT_W(4)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .pll_locked   (pll_locked),
    .rst_n_out    (rst_n_out),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [2:0] pat(input int k);
    return k == 0 ? 3'b001 : k == 1 ? 3'b011 : 3'b111;
  endfunction

  task automatic push(input int c, input logic [2:0] r, input logic y, input logic [3:0] n);
    exp_t e;
    e.cyc = c;
    e.rst = r;
    e.rdy = y;
    e.cnt = n;
    q.push_back(e);
  endtask

  // locked_s is first high two edges after pll_locked is driven at a negedge
  task automatic rise(input int n);
    pll_locked = 1'b1;
    s = cyc + 2;
    for (int k = 0; k < n; k++) push(s + 12 + 2 * k, pat(k), k == 2, cnt_m);
  endtask

  task automatic fall();
    pll_locked = 1'b0;
    cnt_m = cnt_m == 4'd15 ? 4'd15 : cnt_m + 4'd1;
    push(cyc + 3, 3'b000, 1'b0, cnt_m);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc=%0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge sys_clk) begin
    if ({rst_n_out, ready, lock_loss_cnt} !== prev) begin
      prev = {rst_n_out, ready, lock_loss_cnt};
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: cyc=%0d rst=%b ready=%b cnt=%0d", cyc, rst_n_out, ready, lock_loss_cnt);
      end else begin
        em = q.pop_front();
        if (em.cyc != cyc || em.rst !== rst_n_out || em.rdy !== ready || em.cnt !== lock_loss_cnt) begin
          bad++;
          $display("FAIL event: got cyc=%0d rst=%b ready=%b cnt=%0d expected cyc=%0d rst=%b ready=%b cnt=%0d",
                   cyc, rst_n_out, ready, lock_loss_cnt, em.cyc, em.rst, em.rdy, em.cnt);
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    chk("reset_rst", {1'b0, rst_n_out}, 4'h0);
    chk("reset_ready", {3'b000, ready}, 4'h0);
    chk("reset_cnt", lock_loss_cnt, 4'h0);
    sys_rst = 1'b1;
    tick(2);
    pll_locked = 1'b1;
    tick(3);
    pll_locked = 1'b0;
    tick(1);
    rise(3);
    tick(20);
    chk("run_ready", {3'b000, ready}, 4'h1);
    chk("run_cnt", lock_loss_cnt, 4'h0);
    fall();
    tick(6);
    rise(2);
    tick(15);
    fall();
    tick(6);
    chk("mid_release_cnt", lock_loss_cnt, 4'h2);
    rise(3);
    tick(20);
    repeat (20) begin
      fall();
      tick(5);
      rise(3);
      tick(20);
    end
    chk("sat_cnt", lock_loss_cnt, 4'hf);
    fall();
    tick(5);
    rise(0);
    tick(8);
    #1 sys_rst = 1'b0;
    push(cyc + 1, 3'b000, 1'b0, 4'd0);
    cnt_m = 4'd0;
    #1;
    chk("async_cnt", lock_loss_cnt, 4'h0);
    chk("async_rst", {1'b0, rst_n_out}, 4'h0);
    chk("async_ready", {3'b000, ready}, 4'h0);
    tick(3);
    sys_rst = 1'b1;
    rise(3);
    tick(20);
    chk("final_ready", {3'b000, ready}, 4'h1);
    tick(2);
    while (q.size() > 0) begin
      em = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got none expected cyc=%0d rst=%b ready=%b cnt=%0d", em.cyc, em.rst, em.rdy, em.cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
